updown_counter: RTL and testbench
=================================

UPDOWN_COUNTER -- requirements
Module: updown_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the counter width in bits.
REQ-002 The block SHALL have parameter MAX, default 8, giving the terminal (highest) count value.
REQ-003 The block SHALL require 1 <= MAX <= 2^WIDTH-1; an illegal value SHALL stop elaboration with an error.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 clk_en  input  1  count enable; count steps only in cycles where it is high.
REQ-007 clear  input  1  synchronous clear of the count and the sticky flag, independent of clk_en.
REQ-008 load  input  1  synchronous load of load_val, independent of clk_en.
REQ-009 load_val  input  WIDTH  value to load.
REQ-010 up_dn  input  1  direction: 1 = up, 0 = down.
REQ-011 wrap_en  input  1  1 = modulo (wrap) mode, 0 = saturate mode.
REQ-012 q  output  WIDTH  registered count.
REQ-013 tc  output  1  combinational terminal-count level.
REQ-014 wrap_pulse  output  1  registered single-cycle wrap indication.
REQ-015 ovf  output  1  registered sticky flag: wrap or saturation attempt has occurred.

Function
REQ-016 Per-cycle priority SHALL be: clear > load > count step > hold.
REQ-017 When clear is high, the next state SHALL be q=0, ovf=0 and wrap_pulse=0.
REQ-018 When load is high and clear is low, q SHALL take min(load_val, MAX); load_val > MAX is clamped to MAX.
REQ-019 A load SHALL leave ovf unchanged and SHALL drive wrap_pulse=0 next cycle.
REQ-020 Up step, clk_en=1, up_dn=1, q<MAX: q SHALL become q+1.
REQ-021 Down step, clk_en=1, up_dn=0, q>0: q SHALL become q-1.
REQ-022 Up at boundary, q==MAX, wrap_en=1: q SHALL become 0, wrap_pulse SHALL be 1 next cycle, ovf SHALL set.
REQ-023 Up at boundary, q==MAX, wrap_en=0: q SHALL hold at MAX, ovf SHALL set, wrap_pulse SHALL stay 0.
REQ-024 Down at boundary, q==0, wrap_en=1: q SHALL become MAX, wrap_pulse SHALL be 1 next cycle, ovf SHALL set.
REQ-025 Down at boundary, q==0, wrap_en=0: q SHALL hold at 0, ovf SHALL set, wrap_pulse SHALL stay 0.
REQ-026 With clk_en=0 and no clear or load, q and ovf SHALL hold and wrap_pulse SHALL be 0.
REQ-027 tc SHALL equal (up_dn && q==MAX) || (!up_dn && q==0), combinationally, with no clk_en gating.
REQ-028 wrap_pulse SHALL be high for exactly one cycle per wrap event; consecutive wraps give consecutive pulses.
REQ-029 q SHALL never exceed MAX in any sequence of inputs.
REQ-030 Arithmetic SHALL be WIDTH bits; when MAX = 2^WIDTH-1, the up wrap to 0 comes from the explicit compare, not from overflow.
REQ-031 up_dn and wrap_en SHALL be sampled each cycle; a direction change takes effect on the next enabled step.
REQ-032 The next-state and output logic SHALL be synthesizable and free of latches.

Reset
REQ-033 While reset_n is low, q=0, wrap_pulse=0 and ovf=0 SHALL hold asynchronously, regardless of clk.
REQ-034 Reset asserted mid-count SHALL clear state immediately; the first enabled step after release SHALL go from 0.
REQ-035 tc during reset SHALL follow REQ-027 with q=0: 1 when up_dn=0, 0 when up_dn=1.

Verification
REQ-036 Up wrap: WIDTH=8, MAX=8, wrap_en=1, up_dn=1, clk_en=1 for 10 cycles from reset -> q goes 1..8 then 0, 1; wrap_pulse high once, the cycle q=0 appears; ovf=1.
REQ-037 Saturate up: wrap_en=0, 12 enabled up steps -> q stops at 8; tc=1 from the cycle q=8; wrap_pulse never high; ovf=1 after the 9th step.
REQ-038 Down wrap: load 2, then 3 down steps with wrap_en=1 -> q goes 1, 0, 8; tc=1 while q=0; one wrap_pulse.
REQ-039 Priority and clamp: clear=1, load=1, load_val=5 -> q=0. Next cycle load=1, load_val=200, clk_en=1 -> q=8 (clamped, no step); ovf unchanged by the load.
REQ-040 Async reset: q=5, assert reset_n low between clock edges -> q=0 and ovf=0 before the next edge; release, then one up step -> q=1.
REQ-041 Full range: WIDTH=4, MAX=15, wrap_en=1 -> q goes 15 to 0 with wrap_pulse; with wrap_en=0, q holds at 15.

Source files
------------

// File: rtl/updown_counter_if.sv
// -----------------------------------------------------------------------------
// updown_counter_if
// Bundles the control inputs and status outputs of updown_counter.
//   clk_en     : count enable
//   clear      : synchronous clear of count and sticky flag
//   load       : synchronous load of load_val (clamped to MAX)
//   load_val   : value to load
//   up_dn      : direction, 1 = up, 0 = down
//   wrap_en    : 1 = modulo mode, 0 = saturate mode
//   q          : registered count
//   tc         : combinational terminal-count level
//   wrap_pulse : registered single-cycle wrap indication
//   ovf        : registered sticky wrap/saturation flag
// master drives the controls; slave is the counter.
// -----------------------------------------------------------------------------
interface updown_counter_if #(
    parameter int WIDTH = 8
);
    logic             clk_en;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             up_dn;
    logic             wrap_en;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap_pulse;
    logic             ovf;

    modport master (
        output clk_en, clear, load, load_val, up_dn, wrap_en,
        input  q, tc, wrap_pulse, ovf
    );

    modport slave (
        input  clk_en, clear, load, load_val, up_dn, wrap_en,
        output q, tc, wrap_pulse, ovf
    );
endinterface

// File: rtl/updown_counter.sv
// -----------------------------------------------------------------------------
// updown_counter
// Up/down counter over 0..MAX with wrap or saturate behaviour at the ends,
// a one-cycle wrap pulse and a sticky overflow flag.
// Ports:
//   clk     : clock, all state updates on the rising edge
//   reset_n : asynchronous active-low reset (q, wrap_pulse, ovf -> 0)
//   bus     : updown_counter_if slave (controls in, q/tc/wrap_pulse/ovf out)
// Parameters:
//   WIDTH : counter width in bits
//   MAX   : terminal count, 1 <= MAX <= 2^WIDTH-1
// -----------------------------------------------------------------------------
module updown_counter #(
    parameter int WIDTH = 8,
    parameter int MAX   = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    updown_counter_if.slave   bus
);

    // Wide compare so that WIDTH up to 32 does not overflow the bound.
    localparam longint MAX_LEGAL = (longint'(1) << WIDTH) - 1;

    generate
        if (MAX < 1 || longint'(MAX) > MAX_LEGAL) begin : g_bad_max
            $error("updown_counter: MAX=%0d out of range 1..2^WIDTH-1 for WIDTH=%0d", MAX, WIDTH);
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ZERO_V = '0;
    localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q,  wrap_d;
    logic             ovf_q,   ovf_d;

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        wrap_d  = 1'b0;

        if (bus.clear) begin
            count_d = ZERO_V;
            ovf_d   = 1'b0;
        end else if (bus.load) begin
            count_d = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;
        end else if (bus.clk_en) begin
            if (bus.up_dn) begin
                // Explicit end compare: the wrap to 0 never relies on
                // arithmetic overflow, so MAX = 2^WIDTH-1 behaves the same.
                if (count_q == MAX_V) begin
                    ovf_d = 1'b1;
                    if (bus.wrap_en) begin
                        count_d = ZERO_V;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q + ONE_V;
                end
            end else begin
                if (count_q == ZERO_V) begin
                    ovf_d = 1'b1;
                    if (bus.wrap_en) begin
                        count_d = MAX_V;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q - ONE_V;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= ZERO_V;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.q          = count_q;
    assign bus.wrap_pulse = wrap_q;
    assign bus.ovf        = ovf_q;
    // Not gated by clk_en: reflects the end the counter is heading for.
    assign bus.tc         = bus.up_dn ? (count_q == MAX_V) : (count_q == ZERO_V);

endmodule

// File: tb/tb_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_updown_counter
// Two counters: dut_a (WIDTH=8, MAX=8) and dut_b (WIDTH=4, MAX=15).
// Each transaction drives inputs on the falling edge, checks tc, pushes the
// expected next state into a queue, and pops/compares it after the rising edge.
// -----------------------------------------------------------------------------
module tb_updown_counter;

    logic clk;
    logic reset_n;

    updown_counter_if #(.WIDTH(8)) ifa ();
    updown_counter_if #(.WIDTH(4)) ifb ();

    updown_counter #(.WIDTH(8), .MAX(8)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifa)
    );

    updown_counter #(.WIDTH(4), .MAX(15)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit    sel;
        int    q;
        bit    wp;
        bit    ovf;
        string tag;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference state for each counter.
    int ma_q = 0, mb_q = 0;
    bit ma_ovf = 0, mb_ovf = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        ifa.clk_en = 1'b0; ifa.clear = 1'b0; ifa.load = 1'b0;
        ifb.clk_en = 1'b0; ifb.clear = 1'b0; ifb.load = 1'b0;
    endtask

    // One transaction on counter sel (0 = dut_a, 1 = dut_b).
    task automatic txn(input string tag, input bit sel, input bit en, input bit clr,
                       input bit ld, input int lv, input bit ud, input bit we);
        int   mx;
        int   cur;
        int   lv_eff;
        int   nq;
        bit   nw;
        bit   no;
        bit   co;
        bit   exp_tc;
        exp_t e;
        exp_t got;
        logic [31:0] obs_q;
        logic        obs_wp, obs_ovf, obs_tc;

        mx     = sel ? 15 : 8;
        cur    = sel ? mb_q : ma_q;
        co     = sel ? mb_ovf : ma_ovf;
        lv_eff = sel ? (lv % 16) : (lv % 256);

        @(negedge clk);
        if (sel) begin
            ifb.clk_en = en; ifb.clear = clr; ifb.load = ld;
            ifb.load_val = 4'(lv_eff); ifb.up_dn = ud; ifb.wrap_en = we;
        end else begin
            ifa.clk_en = en; ifa.clear = clr; ifa.load = ld;
            ifa.load_val = 8'(lv_eff); ifa.up_dn = ud; ifa.wrap_en = we;
        end
        #1;
        obs_tc = sel ? ifb.tc : ifa.tc;
        exp_tc = ud ? (cur == mx) : (cur == 0);
        check_val({tag, ".tc"}, 32'(obs_tc), 32'(exp_tc));

        nq = cur; nw = 1'b0; no = co;
        if (clr) begin
            nq = 0; no = 1'b0;
        end else if (ld) begin
            nq = (lv_eff > mx) ? mx : lv_eff;
        end else if (en && ud) begin
            if (cur < mx) nq = cur + 1;
            else begin
                no = 1'b1;
                if (we) begin nq = 0; nw = 1'b1; end
            end
        end else if (en && !ud) begin
            if (cur > 0) nq = cur - 1;
            else begin
                no = 1'b1;
                if (we) begin nq = mx; nw = 1'b1; end
            end
        end
        e.sel = sel; e.q = nq; e.wp = nw; e.ovf = no; e.tag = tag;
        sb.push_back(e);
        if (sel) begin mb_q = nq; mb_ovf = no; end
        else     begin ma_q = nq; ma_ovf = no; end

        @(posedge clk);
        #1;
        set_idle();
        got     = sb.pop_front();
        obs_q   = got.sel ? 32'(ifb.q) : 32'(ifa.q);
        obs_wp  = got.sel ? ifb.wrap_pulse : ifa.wrap_pulse;
        obs_ovf = got.sel ? ifb.ovf : ifa.ovf;
        $display("[%0t] %s dut_%s q=%0d wrap_pulse=%0b ovf=%0b (exp q=%0d wp=%0b ovf=%0b)",
                 $time, got.tag, got.sel ? "b" : "a", obs_q, obs_wp, obs_ovf,
                 got.q, got.wp, got.ovf);
        check_val({got.tag, ".q"},    obs_q,          32'(got.q));
        check_val({got.tag, ".wrap"}, 32'(obs_wp),    32'(got.wp));
        check_val({got.tag, ".ovf"},  32'(obs_ovf),   32'(got.ovf));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        set_idle();
        ifa.load_val = '0; ifa.up_dn = 1'b0; ifa.wrap_en = 1'b1;
        ifb.load_val = '0; ifb.up_dn = 1'b1; ifb.wrap_en = 1'b1;

        // Reset state, and tc following up_dn with q=0.
        #3;
        check_val("rst.q",    32'(ifa.q), 32'd0);
        check_val("rst.wrap", 32'(ifa.wrap_pulse), 32'd0);
        check_val("rst.ovf",  32'(ifa.ovf), 32'd0);
        check_val("rst.tc_dn", 32'(ifa.tc), 32'd1);
        ifa.up_dn = 1'b1;
        #1;
        check_val("rst.tc_up", 32'(ifa.tc), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Up wrap: 10 enabled up steps from 0.
        for (int i = 0; i < 10; i++) txn($sformatf("upwrap%0d", i), 0, 1, 0, 0, 0, 1, 1);

        // Saturate up: 12 steps from a cleared counter.
        txn("clr1", 0, 0, 1, 0, 0, 1, 0);
        for (int i = 0; i < 12; i++) txn($sformatf("sat%0d", i), 0, 1, 0, 0, 0, 1, 0);

        // Down wrap: load 2 then three down steps.
        txn("clr2", 0, 0, 1, 0, 0, 0, 1);
        txn("ld2",  0, 0, 0, 1, 2, 0, 1);
        for (int i = 0; i < 3; i++) txn($sformatf("dnwrap%0d", i), 0, 1, 0, 0, 0, 0, 1);

        // Consecutive wraps: up from MAX then down from 0.
        txn("cwrap_up", 0, 1, 0, 0, 0, 1, 1);
        txn("cwrap_dn", 0, 1, 0, 0, 0, 0, 1);

        // Hold with clk_en low.
        txn("hold0", 0, 0, 0, 0, 0, 1, 1);
        txn("hold1", 0, 0, 0, 0, 0, 0, 0);

        // Priority and clamp.
        txn("prio_clr", 0, 1, 1, 1, 5, 1, 1);
        txn("clamp",    0, 1, 0, 1, 200, 1, 1);
        txn("sat_set",  0, 1, 0, 0, 0, 1, 0);
        txn("ld_keep",  0, 1, 0, 1, 3, 1, 0);
        txn("dn_step",  0, 1, 0, 0, 0, 0, 0);

        // Async reset mid-count.
        txn("ld5", 0, 0, 0, 1, 5, 1, 1);
        #2;
        reset_n = 1'b0;
        #1;
        ma_q = 0; ma_ovf = 1'b0; mb_q = 0; mb_ovf = 1'b0;
        check_val("arst.q",   32'(ifa.q), 32'd0);
        check_val("arst.ovf", 32'(ifa.ovf), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        txn("post_rst", 0, 1, 0, 0, 0, 1, 1);

        // Full-range counter: WIDTH=4, MAX=15.
        txn("b_ld14", 1, 0, 0, 1, 14, 1, 1);
        for (int i = 0; i < 3; i++) txn($sformatf("b_wrap%0d", i), 1, 1, 0, 0, 0, 1, 1);
        txn("b_ld15", 1, 0, 0, 1, 15, 1, 0);
        txn("b_sat0", 1, 1, 0, 0, 0, 1, 0);
        txn("b_sat1", 1, 1, 0, 0, 0, 1, 0);
        txn("b_dn",   1, 1, 0, 0, 0, 0, 1);

        // Random mix on dut_a.
        for (int i = 0; i < 60; i++) begin
            txn($sformatf("rnd%0d", i), 0,
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 15) == 0,
                $urandom_range(0, 7) == 0,
                int'($urandom_range(0, 255)),
                $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
